player_input_hub: RTL and testbench
===================================

// Module: player_input_hub
// PURPOSE
//  Parametrised N-player front end between the raw game-controller inputs and the processor.
//  - Inputs: joystick/switch direction lines, pause button, per-player wall-collision flags.
//  - Outputs, per player: debounced direction levels, a latched 2-bit heading, a moving flag.
//  - Outputs, global: a pause state and a one-cycle pause pulse.
//  - Sits between the top-level pins and proc_skeleton; replaces the direct JoyN/sw4..7 wiring.
// PARAMETERS
//  NUM_PLAYERS      2      number of players (1..4)
//  DEBOUNCE_CYCLES  16'd50000  consecutive stable cycles needed before a debounced level changes (>=2)
//  TURN_HOLD_CYCLES 24'd2500000  lifetime of a buffered turn request (used only with the macro)
// PORTS
//  clock         in   1            system clock (50 MHz)
//  resetn        in   1            synchronous reset, active low
//  dir_raw       in   4*NUM_PLAYERS  per player {left,down,right,up}, active high, asynchronous
//  collision     in   4*NUM_PLAYERS  per player {left,down,right,up}; 1 = that move is blocked
//  pause_raw     in   1            pause button, active high, asynchronous
//  dir_held      out  4*NUM_PLAYERS  debounced direction levels
//  heading       out  2*NUM_PLAYERS  latched heading per player: 0=up 1=right 2=down 3=left
//  moving        out  NUM_PLAYERS  1 = player's current heading is not blocked
//  paused        out  1            pause state
//  pause_pulse   out  1            one-cycle strobe on every pause toggle
// BEHAVIOUR
//  Reset
//   - While resetn=0 at a clock edge: all outputs are 0, all debounce counters are 0, all synchronisers are 0.
//   - Headings reset to up (0). No pending turns.
//   - A reset asserted mid-debounce or mid-hold discards that progress.
//  Synchroniser
//   - Every raw bit passes through a 2-flop synchroniser before use.
//  Debounce
//   - There is one counter per bit, 4*NUM_PLAYERS+1 bits in total.
//   - The counter increments while the synchronised bit differs from the stable bit. It clears when they are equal.
//   - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable bit flips and the counter clears.
//   - The counter saturates and never wraps.
//  Latency from a clean raw change at edge 0
//   - dir_held changes at edge 2+DEBOUNCE_CYCLES.
//   - heading, moving, paused and pause_pulse change 1 edge later.
//  Heading update, per player, every cycle
//   - Requested direction = highest-priority held bit. Priority: up > right > down > left.
//   - If no bit is held: heading holds.
//   - If the requested direction's collision bit is 0: heading takes the requested direction.
//   - If the requested direction's collision bit is 1: heading holds (macro changes this; see CONFIGURATION).
//  Moving
//   - moving = ~collision[heading], registered.
//   - It is recomputed every cycle, including on the cycle the heading changes; the new heading is used.
//  Pause
//   - A rising edge of the debounced pause toggles paused. pause_pulse=1 for exactly that cycle.
//   - Releasing the button has no effect.
//   - Headings keep updating while paused; the processor gates motion.
//  Simultaneous opposite directions (e.g. up+down)
//   - Resolved by priority; no error is raised.
// CONFIGURATION
//  Macro TURN_BUFFER_EN, when defined:
//   - Each player gets a pending turn register (valid, 2-bit direction) and a hold counter.
//   - A blocked request loads pending and clears the hold counter.
//   - A newer different blocked request overwrites pending.
//   - Pending is applied to heading on the first cycle its collision bit is 0, then cleared.
//   - An unblocked request applies immediately and clears pending.
//   - Pending expires when the hold counter reaches TURN_HOLD_CYCLES-1.
//   - Expiry and apply in the same cycle: apply wins.
//  Macro TURN_BUFFER_EN, when undefined:
//   - Blocked requests are dropped.
//   - No pending state is synthesised.
// STRUCTURE
//  Shared package/header pacman_input_defs
//   - Direction constants DIR_UP=2'd0, DIR_RIGHT=2'd1, DIR_DOWN=2'd2, DIR_LEFT=2'd3.
//   - Bit-index constants for the 4-bit direction vectors.
//  Sub-module input_debouncer
//   - Parameter DEBOUNCE_CYCLES. Ports clock, resetn, raw, stable, rise.
//   - Contains one synchroniser and one debounce counter.
//   - Instantiated with a generate loop, 4*NUM_PLAYERS+1 times.
//  Heading/turn logic is a generate loop over players inside this module.
// TESTING  (DEBOUNCE_CYCLES=4, TURN_HOLD_CYCLES=8, NUM_PLAYERS=2)
//  1. Reset with resetn=0 for 3 cycles, dir_raw=8'hFF -> all outputs 0, heading=4'b0000.
//  2. Glitch and clean press on player 0
//     - Glitch: dir_raw[1] high for 3 cycles -> dir_held unchanged, no heading change.
//     - Clean press: hold it 10 cycles -> dir_held[1]=1 at edge 6, heading[1:0]=1 at edge 7.
//  3. Priority: player 1 up+left held, collision=0 -> heading[3:2]=0. Then release up -> heading[3:2]=3.
//  4. Blocked turn: player 0 heading=1, press down with collision[2]=1
//     - Without macro: heading stays 1; moving[0] follows collision[1].
//     - With TURN_BUFFER_EN: clear collision[2] 5 cycles later -> heading=2 the next edge.
//     - With TURN_BUFFER_EN: clear collision[2] 12 cycles later -> heading stays 1.
//  5. Pause: press pause_raw twice, each held 10 cycles
//     - paused 0->1->0; pause_pulse high exactly 2 cycles total.
//     - Assert resetn=0 during the second press -> paused=0, no pulse.

Source files
------------

// File: rtl/pacman_input_defs.sv
// Shared direction encoding and request-priority helper for the player input hub.
package pacman_input_defs;

  localparam int unsigned DIR_W = 4;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam int unsigned BIT_UP    = 0;
  localparam int unsigned BIT_RIGHT = 1;
  localparam int unsigned BIT_DOWN  = 2;
  localparam int unsigned BIT_LEFT  = 3;

  typedef struct packed {
    logic       valid;
    logic [1:0] dir;
  } dir_req_t;

  // Highest-priority held direction: up > right > down > left.
  function automatic dir_req_t pick_dir(input logic [DIR_W-1:0] held);
    dir_req_t r;
    r.valid = 1'b1;
    if (held[BIT_UP])         r.dir = DIR_UP;
    else if (held[BIT_RIGHT]) r.dir = DIR_RIGHT;
    else if (held[BIT_DOWN])  r.dir = DIR_DOWN;
    else if (held[BIT_LEFT])  r.dir = DIR_LEFT;
    else begin
      r.valid = 1'b0;
      r.dir   = DIR_UP;
    end
    return r;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a saturating stable-run debounce counter.
module input_debouncer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic stable,
  output logic rise
);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        stable_q, stable_d;
  logic        rise_q, rise_d;
  logic [15:0] cnt_q, cnt_d;

  // Count cycles the synchronised bit disagrees with the stable level; flip once the run is long enough.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    cnt_d    = 16'd0;
    if (sync2_q != stable_q) begin
      if (cnt_q >= DEBOUNCE_CYCLES - 16'd1) begin
        stable_d = ~stable_q;
        rise_d   = ~stable_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;

endmodule

// File: rtl/player_input_hub.sv
// N-player controller front end: debounced directions, latched headings, moving flags, pause toggle.
// Optional macro TURN_BUFFER_EN buffers blocked turn requests for up to TURN_HOLD_CYCLES cycles.
module player_input_hub
  import pacman_input_defs::*;
#(
  parameter int unsigned NUM_PLAYERS      = 2,
  parameter logic [15:0] DEBOUNCE_CYCLES  = 16'd50000,
  parameter logic [23:0] TURN_HOLD_CYCLES = 24'd2500000
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [4*NUM_PLAYERS-1:0]   dir_raw,
  input  logic [4*NUM_PLAYERS-1:0]   collision,
  input  logic                       pause_raw,
  output logic [4*NUM_PLAYERS-1:0]   dir_held,
  output logic [2*NUM_PLAYERS-1:0]   heading,
  output logic [NUM_PLAYERS-1:0]     moving,
  output logic                       paused,
  output logic                       pause_pulse
);

  localparam int unsigned NUM_DIR_BITS = DIR_W * NUM_PLAYERS;

`ifndef TURN_BUFFER_EN
  localparam logic [23:0] TURN_HOLD_UNUSED = TURN_HOLD_CYCLES;
`endif

  logic [NUM_DIR_BITS-1:0] dir_stable;
  logic [NUM_DIR_BITS-1:0] dir_rise_unused;
  logic                    pause_level_unused;
  logic                    pause_rise;

  for (genvar i = 0; i < int'(NUM_DIR_BITS); i++) begin : g_dir_db
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock  (clock),
      .resetn (resetn),
      .raw    (dir_raw[i]),
      .stable (dir_stable[i]),
      .rise   (dir_rise_unused[i])
    );
  end

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
    .clock  (clock),
    .resetn (resetn),
    .raw    (pause_raw),
    .stable (pause_level_unused),
    .rise   (pause_rise)
  );

  assign dir_held = dir_stable;

  for (genvar p = 0; p < int'(NUM_PLAYERS); p++) begin : g_player
    logic [DIR_W-1:0] held;
    logic [DIR_W-1:0] blocked;
    dir_req_t         req;
    logic [1:0]       head_q, head_d;
    logic             move_q, move_d;

    assign held    = dir_stable[DIR_W*p +: DIR_W];
    assign blocked = collision[DIR_W*p +: DIR_W];
    assign req     = pick_dir(held);

`ifdef TURN_BUFFER_EN
    logic        pend_valid_q, pend_valid_d;
    logic [1:0]  pend_dir_q, pend_dir_d;
    logic [23:0] hold_q, hold_d;

    // Heading update with a pending-turn buffer; apply beats expiry.
    always_comb begin
      head_d       = head_q;
      pend_valid_d = pend_valid_q;
      pend_dir_d   = pend_dir_q;
      hold_d       = hold_q;
      if (req.valid && !blocked[req.dir]) begin
        head_d       = req.dir;
        pend_valid_d = 1'b0;
        hold_d       = 24'd0;
      end else if (req.valid && (!pend_valid_q || (pend_dir_q != req.dir))) begin
        pend_valid_d = 1'b1;
        pend_dir_d   = req.dir;
        hold_d       = 24'd0;
      end else if (pend_valid_q && !blocked[pend_dir_q]) begin
        head_d       = pend_dir_q;
        pend_valid_d = 1'b0;
        hold_d       = 24'd0;
      end else if (pend_valid_q) begin
        if (hold_q >= TURN_HOLD_CYCLES - 24'd1) begin
          pend_valid_d = 1'b0;
          hold_d       = 24'd0;
        end else begin
          hold_d = hold_q + 24'd1;
        end
      end
      move_d = ~blocked[head_d];
    end

    // Pending-turn registers.
    always_ff @(posedge clock) begin
      if (!resetn) begin
        pend_valid_q <= 1'b0;
        pend_dir_q   <= DIR_UP;
        hold_q       <= 24'd0;
      end else begin
        pend_valid_q <= pend_valid_d;
        pend_dir_q   <= pend_dir_d;
        hold_q       <= hold_d;
      end
    end
`else
    // Heading follows the requested direction only when it is not blocked.
    always_comb begin
      head_d = head_q;
      if (req.valid && !blocked[req.dir]) begin
        head_d = req.dir;
      end
      move_d = ~blocked[head_d];
    end
`endif

    // Heading and moving registers.
    always_ff @(posedge clock) begin
      if (!resetn) begin
        head_q <= DIR_UP;
        move_q <= 1'b0;
      end else begin
        head_q <= head_d;
        move_q <= move_d;
      end
    end

    assign heading[2*p +: 2] = head_q;
    assign moving[p]         = move_q;
  end

  logic paused_q, paused_d;
  logic pulse_q, pulse_d;

  // Toggle pause on each debounced press.
  always_comb begin
    paused_d = paused_q ^ pause_rise;
    pulse_d  = pause_rise;
  end

  // Pause registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      paused_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      paused_q <= paused_d;
      pulse_q  <= pulse_d;
    end
  end

  assign paused      = paused_q;
  assign pause_pulse = pulse_q;

endmodule

// File: tb/tb_player_input_hub.sv
// Randomised bench for player_input_hub with a behavioural reference model.
module tb_player_input_hub;

  localparam int N = 2;
  localparam int D = 4;
  localparam int T = 8;
  localparam int NB = 4 * N;

  logic           clock = 1'b0;
  logic           resetn;
  logic [NB-1:0]  dir_raw;
  logic [NB-1:0]  collision;
  logic           pause_raw;
  logic [NB-1:0]  dir_held;
  logic [2*N-1:0] heading;
  logic [N-1:0]   moving;
  logic           paused;
  logic           pause_pulse;

  player_input_hub #(
    .NUM_PLAYERS      (N),
    .DEBOUNCE_CYCLES  (16'(D)),
    .TURN_HOLD_CYCLES (24'(T))
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .dir_raw     (dir_raw),
    .collision   (collision),
    .pause_raw   (pause_raw),
    .dir_held    (dir_held),
    .heading     (heading),
    .moving      (moving),
    .paused      (paused),
    .pause_pulse (pause_pulse)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int pulse_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: input index NB is the pause button.
  bit m_s1   [NB+1];
  bit m_s2   [NB+1];
  bit m_stab [NB+1];
  int m_run  [NB+1];
  bit m_press;
  int m_head [N];
  bit m_mov  [N];
  bit m_paused, m_pulse;
  bit m_pv   [N];
  int m_pd   [N];
  int m_pload[N];
  int cyc = 0;

  always @(posedge clock) begin
    bit old_press;
    bit held [NB];
    int req;
    cyc++;
    if (!resetn) begin
      for (int b = 0; b <= NB; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_stab[b] = 0; m_run[b] = 0;
      end
      for (int p = 0; p < N; p++) begin
        m_head[p] = 0; m_mov[p] = 0; m_pv[p] = 0;
      end
      m_press = 0; m_paused = 0; m_pulse = 0;
    end else begin
      old_press = m_press;
      for (int b = 0; b < NB; b++) held[b] = m_stab[b];
      m_pulse = old_press;
      if (old_press) m_paused = !m_paused;
      for (int p = 0; p < N; p++) begin
        req = -1;
        for (int d = 3; d >= 0; d--) if (held[4*p+d]) req = d;
        if (req >= 0 && !collision[4*p+req]) begin
          m_head[p] = req;
          m_pv[p] = 0;
        end
`ifdef TURN_BUFFER_EN
        else if (req >= 0 && (!m_pv[p] || m_pd[p] != req)) begin
          m_pv[p] = 1; m_pd[p] = req; m_pload[p] = cyc;
        end else if (m_pv[p] && !collision[4*p+m_pd[p]]) begin
          m_head[p] = m_pd[p];
          m_pv[p] = 0;
        end else if (m_pv[p] && (cyc - m_pload[p]) >= T) begin
          m_pv[p] = 0;
        end
`endif
        m_mov[p] = !collision[4*p+m_head[p]];
      end
      m_press = 0;
      for (int b = 0; b <= NB; b++) begin
        if (m_s2[b] != m_stab[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin
            m_stab[b] = !m_stab[b];
            m_run[b] = 0;
            if (b == NB && m_stab[b]) m_press = 1;
          end
        end else begin
          m_run[b] = 0;
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = (b == NB) ? pause_raw : dir_raw[b];
      end
    end
  end

  task automatic compare_all(input string phase);
    logic [NB-1:0]  eh;
    logic [2*N-1:0] ehd;
    logic [N-1:0]   emv;
    for (int b = 0; b < NB; b++) eh[b] = m_stab[b];
    for (int p = 0; p < N; p++) begin
      ehd[2*p +: 2] = 2'(m_head[p]);
      emv[p] = m_mov[p];
    end
    check({phase, ".dir_held"}, 32'(dir_held), 32'(eh));
    check({phase, ".heading"}, 32'(heading), 32'(ehd));
    check({phase, ".moving"}, 32'(moving), 32'(emv));
    check({phase, ".paused"}, 32'(paused), 32'(m_paused));
    check({phase, ".pause_pulse"}, 32'(pause_pulse), 32'(m_pulse));
  endtask

  task automatic step(input int n, input string phase);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (pause_pulse) pulse_cnt++;
      compare_all(phase);
    end
  endtask

  initial begin
    resetn = 1'b0; dir_raw = '1; collision = '0; pause_raw = 1'b0;
    repeat (3) @(negedge clock);
    check("reset.dir_held", 32'(dir_held), 32'd0);
    check("reset.heading", 32'(heading), 32'd0);
    check("reset.moving", 32'(moving), 32'd0);
    check("reset.paused", 32'(paused), 32'd0);
    check("reset.pause_pulse", 32'(pause_pulse), 32'd0);

    // Glitch shorter than the debounce window.
    dir_raw = '0; resetn = 1'b1;
    step(2, "idle");
    dir_raw[1] = 1'b1;
    step(3, "glitch");
    dir_raw[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1, "glitch");
      check("glitch.held_low", 32'(dir_held), 32'd0);
      check("glitch.heading_up", 32'(heading), 32'd0);
    end

    // Clean press: debounced at edge 6, heading at edge 7.
    dir_raw = 8'h02;
    for (int k = 1; k <= 10; k++) begin
      step(1, "press");
      check("press.dir_held", 32'(dir_held), (k >= 6) ? 32'h2 : 32'h0);
      check("press.heading", 32'(heading), (k >= 7) ? 32'h1 : 32'h0);
    end
    dir_raw = '0;
    step(10, "release");

    // Two clean pause presses.
    pulse_cnt = 0;
    pause_raw = 1'b1; step(10, "pause1");
    pause_raw = 1'b0; step(10, "pause1");
    check("pause.after_first", 32'(paused), 32'd1);
    pause_raw = 1'b1; step(10, "pause2");
    pause_raw = 1'b0; step(10, "pause2");
    check("pause.after_second", 32'(paused), 32'd0);
    check("pause.pulse_count", 32'(pulse_cnt), 32'd2);

    // Reset mid-debounce discards the press.
    pulse_cnt = 0;
    pause_raw = 1'b1; step(4, "pause_rst");
    resetn = 1'b0; pause_raw = 1'b0; step(2, "pause_rst");
    resetn = 1'b1; step(12, "pause_rst");
    check("pause_rst.paused", 32'(paused), 32'd0);
    check("pause_rst.pulse_count", 32'(pulse_cnt), 32'd0);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 11) == 0) dir_raw[b] = ~dir_raw[b];
        if ($urandom_range(0, 19) == 0) collision[b] = ~collision[b];
      end
      if ($urandom_range(0, 24) == 0) pause_raw = ~pause_raw;
      resetn = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      step(1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
